ct_spsram_128x16_ctrl: RTL and testbench

Initiator-side access controller for the 128x16 single-port SRAM macro wrapper. It turns a valid/ready request stream into the macro's active-low CEN/GWEN/WEN pin protocol. It captures the macro's one-cycle-late read data into a response buffer, and it optionally zero-fills the array after reset. It sits between IFU-side requesters and the SRAM wrapper instance.

---
 rtl/ct_spsram_128x16_ctrl_pkg.sv | 26 ++
 rtl/ct_spsram_ctrl_rsp_fifo.sv | 57 +++++
 rtl/ct_spsram_128x16_ctrl.sv | 133 +++++++++++++
 tb/tb_ct_spsram_128x16_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_128x16_ctrl_pkg.sv
// Shared constants, state encoding and idle pin values for the 128x16 SRAM access controller.
package ct_spsram_128x16_ctrl_pkg;

    localparam int SRAM_AW        = 7;
    localparam int SRAM_DW        = 16;
    localparam int SRAM_WEW       = 16;
    localparam int RSP_FIFO_DEPTH = 3;
    localparam int RSP_CNT_W      = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrlState_e;

    // Macro pins are active-low, so idle means everything deasserted high with a/d parked at zero.
    localparam logic IDLE_CEN     = 1'b1;
    localparam logic IDLE_GWEN    = 1'b1;
    localparam logic IDLE_WEN_BIT = 1'b1;
    localparam logic IDLE_A_BIT   = 1'b0;
    localparam logic IDLE_D_BIT   = 1'b0;

    function automatic logic [RSP_CNT_W-1:0] fifoPtrInc(input logic [RSP_CNT_W-1:0] ptr);
        return (ptr == RSP_CNT_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + RSP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// Three-entry in-order response buffer; push and pop may coincide with the count unchanged.
module ct_spsram_ctrl_rsp_fifo
    import ct_spsram_128x16_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] pushData_i,
    input  logic                  pop_i,
    output logic [RSP_CNT_W-1:0]  count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
    logic [RSP_CNT_W-1:0]  wrPtr_q, wrPtr_d;
    logic [RSP_CNT_W-1:0]  rdPtr_q, rdPtr_d;
    logic [RSP_CNT_W-1:0]  count_q, count_d;
    logic                  doPush, doPop;

    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != RSP_CNT_W'(RSP_FIFO_DEPTH)) || doPop);

    always_comb begin
        wrPtr_d = doPush ? fifoPtrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop  ? fifoPtrInc(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + RSP_CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - RSP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/ct_spsram_128x16_ctrl.sv
// Access controller for the 128x16 single-port SRAM macro: request stream to CEN/GWEN/WEN pins,
// read-response buffering, and an optional post-reset zero fill selected by CT_SPSRAM_CTRL_INIT_EN.
module ct_spsram_128x16_ctrl
    import ct_spsram_128x16_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_AW,
    parameter int DATA_WIDTH = SRAM_DW,
    parameter int WE_WIDTH   = SRAM_WEW
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [WE_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [RSP_CNT_W:0] CREDIT_LIMIT = (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH);

`ifdef CT_SPSRAM_CTRL_INIT_EN
    localparam ctrlState_e RESET_STATE = ST_INIT;
`else
    localparam ctrlState_e RESET_STATE = ST_RUN;
`endif

    ctrlState_e            state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [RSP_CNT_W-1:0]  fifoCount;
    logic [DATA_WIDTH-1:0] fifoHead;
    logic [RSP_CNT_W:0]    occupancy;
    logic                  canAccept, reqHs, readHs, writeHs, rspPop;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] initCnt_q, initCnt_d;
`endif

    // Credit counts buffered plus in-flight reads from registers only, keeping req_rdy free of input paths.
    assign occupancy  = {1'b0, fifoCount} + {{RSP_CNT_W{1'b0}}, inflight_q};
    assign canAccept  = (state_q == ST_RUN) && (occupancy < CREDIT_LIMIT);
    assign reqHs      = req_vld && canAccept;
    assign readHs     = reqHs && !req_wr;
    assign writeHs    = reqHs && req_wr && (req_wmask != '0);
    assign rspPop     = rsp_vld && rsp_rdy;
    assign inflight_d = readHs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RESET_STATE;
            inflight_q <= 1'b0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
            initCnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
`ifdef CT_SPSRAM_CTRL_INIT_EN
            initCnt_q  <= initCnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        initCnt_d = (state_q == ST_INIT) ? initCnt_q + ADDR_WIDTH'(1) : '0;
        if ((state_q == ST_INIT) && (initCnt_q == '1)) begin
            state_d = ST_RUN;
        end
`endif
    end

    // The macro registers its pins, so they follow the handshake combinationally in the same cycle.
    always_comb begin
        sram_cen  = IDLE_CEN;
        sram_gwen = IDLE_GWEN;
        sram_wen  = {WE_WIDTH{IDLE_WEN_BIT}};
        sram_a    = {ADDR_WIDTH{IDLE_A_BIT}};
        sram_d    = {DATA_WIDTH{IDLE_D_BIT}};
        req_rdy   = canAccept;
        init_done = (state_q == ST_RUN);
        case (state_q)
            ST_INIT: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                if (!RST) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = initCnt_q;
                end
`endif
            end
            ST_RUN: begin
                if (readHs) begin
                    sram_cen = 1'b0;
                    sram_a   = req_addr;
                end else if (writeHs) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = ~req_wmask;
                    sram_a    = req_addr;
                    sram_d    = req_wdata;
                end
            end
        endcase
    end

    ct_spsram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rspFifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .push_i     (inflight_q),
        .pushData_i (sram_q),
        .pop_i      (rspPop),
        .count_o    (fifoCount),
        .head_o     (fifoHead)
    );

    assign rsp_vld   = (fifoCount != '0);
    assign rsp_rdata = fifoHead;

endmodule

// File: tb/tb_ct_spsram_128x16_ctrl.sv
// Directed bench for ct_spsram_128x16_ctrl with a behavioural SRAM macro and a read scoreboard.
// Init-sweep expectations follow the CT_SPSRAM_CTRL_INIT_EN build option.
module tb_ct_spsram_128x16_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_wr = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] req_wmask = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [15:0] rsp_rdata;
    logic        init_done;
    logic [6:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [15:0] sram_wen;
    logic [15:0] sram_d;
    logic [15:0] sram_q;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          exact;
    } expEntry_t;

    expEntry_t   sbQ[$];
    expEntry_t   monEntry;
    logic [15:0] refMem [128];
    logic [15:0] macroMem [128];
    logic [15:0] macroWord;
    int          cyc = 0;
    int          passCount = 0;
    int          failCount = 0;
    int          totalCount = 0;

    ct_spsram_128x16_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural macro: registered pins, per-bit active-low write, Q updated only on reads.
    initial begin
        for (int k = 0; k < 128; k++) begin
            macroMem[k] = 16'($urandom);
            refMem[k]   = 16'h0000;
        end
        forever begin
            @(posedge CLK);
            if (sram_cen === 1'b0) begin
                if (sram_gwen === 1'b0) begin
                    macroWord = (macroMem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
                    macroMem[sram_a] = macroWord;
                end else begin
                    sram_q <= macroMem[sram_a];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge and records accepted requests.
    task automatic applyStimulus(input logic vld, input logic wr, input logic [6:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] wmask,
                                 input logic rspReady, input bit exact, output bit hs);
        expEntry_t e;
        @(negedge CLK);
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        rsp_rdy   = rspReady;
        #1;
        hs = (req_vld === 1'b1) && (req_rdy === 1'b1);
        if (hs) begin
            if (!wr) begin
                e.data  = refMem[addr];
                e.cyc   = cyc;
                e.exact = exact;
                sbQ.push_back(e);
            end else begin
                refMem[addr] = (refMem[addr] & ~wmask) | (wdata & wmask);
            end
        end
    endtask

    task automatic idleCycles(input int n, input logic rspReady);
        bit hs;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 7'h00, 16'h0000, 16'h0000, rspReady, 1'b0, hs);
    endtask

    task automatic drain();
        bit hs;
        for (int n = 0; n < 20 && sbQ.size() != 0; n++) begin
            applyStimulus(1'b0, 1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, hs);
        end
        idleCycles(2, 1'b1);
        checkOutput("drain_sb_empty", sbQ.size(), 0);
        checkOutput("drain_rsp_vld", rsp_vld, 1'b0);
    endtask

    // Assert RST for one edge, release it, then check the first post-reset cycles.
    task automatic doReset();
        @(negedge CLK);
        RST     = 1'b1;
        req_vld = 1'b0;
        rsp_rdy = 1'b0;
        sbQ.delete();
        @(negedge CLK);
        RST     = 1'b0;
        rsp_rdy = 1'b1;
        #1;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        for (int i = 0; i < 128; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                #1;
            end
            checkOutput($sformatf("init_pins_%0d", i),
                        {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                        {1'b0, 1'b0, 16'h0000, 7'(i), 16'h0000});
            checkOutput($sformatf("init_status_%0d", i), {init_done, req_rdy, rsp_vld}, 3'b000);
        end
        @(negedge CLK);
        #1;
        checkOutput("init_done_rise", {init_done, req_rdy}, 2'b11);
        checkOutput("init_end_idle", sram_cen, 1'b1);
        for (int k = 0; k < 128; k++) refMem[k] = 16'h0000;
`else
        checkOutput("noinit_ready", {init_done, req_rdy}, 2'b11);
        checkOutput("noinit_rsp_vld", rsp_vld, 1'b0);
        checkOutput("noinit_idle_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                    {1'b1, 1'b1, 16'hFFFF, 7'h00, 16'h0000});
`endif
    endtask

    // Scoreboard monitor: every popped response must match the oldest accepted read.
    always begin
        @(negedge CLK);
        #1;
        if ((rsp_vld === 1'b1) && (rsp_rdy === 1'b1)) begin
            if (sbQ.size() == 0) begin
                checkOutput("rsp_unexpected", rsp_rdata, 16'hxxxx);
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("rsp_data", rsp_rdata, monEntry.data);
                if (monEntry.exact) checkOutput("rsp_latency", cyc, monEntry.cyc + 2);
            end
        end
    end

    initial begin
        bit hs;
        $display("[TB] start");
        doReset();

`ifdef CT_SPSRAM_CTRL_INIT_EN
        applyStimulus(1'b1, 1'b0, 7'h55, 16'h0000, 16'h0000, 1'b1, 1'b1, hs);
        checkOutput("rd55_hs", hs, 1'b1);
        idleCycles(3, 1'b1);
`endif

        applyStimulus(1'b1, 1'b1, 7'h10, 16'hA5A5, 16'hFFFF, 1'b1, 1'b0, hs);
        checkOutput("wr_full_hs", hs, 1'b1);
        checkOutput("wr_full_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                    {1'b0, 1'b0, 16'h0000, 7'h10, 16'hA5A5});
        applyStimulus(1'b1, 1'b1, 7'h10, 16'h00FF, 16'h00F0, 1'b1, 1'b0, hs);
        checkOutput("wr_mask_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                    {1'b0, 1'b0, 16'hFF0F, 7'h10, 16'h00FF});
        applyStimulus(1'b1, 1'b0, 7'h10, 16'h0000, 16'h0000, 1'b1, 1'b1, hs);
        checkOutput("rd10_pins", {sram_cen, sram_gwen, sram_wen, sram_a}, {1'b0, 1'b1, 16'hFFFF, 7'h10});
        checkOutput("rd10_expect", refMem[7'h10], 16'hA5F5);
        idleCycles(1, 1'b1);
        checkOutput("rd10_not_early", rsp_vld, 1'b0);
        idleCycles(3, 1'b1);

        applyStimulus(1'b1, 1'b1, 7'h20, 16'h1234, 16'h0000, 1'b1, 1'b0, hs);
        checkOutput("wr_nomask_hs", hs, 1'b1);
        checkOutput("wr_nomask_cen", sram_cen, 1'b1);
        idleCycles(3, 1'b1);
        checkOutput("wr_nomask_no_rsp", rsp_vld, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 7'(48 + i), 16'(16'hBEE0 + i), 16'hFFFF, 1'b1, 1'b0, hs);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 7'(48 + i), 16'h0000, 16'h0000, 1'b0, 1'b0, hs);
            checkOutput($sformatf("full_hs_%0d", i), hs, 1'b1);
        end
        idleCycles(1, 1'b0);
        checkOutput("full_rdy_drop", req_rdy, 1'b0);
        checkOutput("full_rsp_vld", rsp_vld, 1'b1);
        idleCycles(1, 1'b0);
        checkOutput("full_rdy_held", req_rdy, 1'b0);
        idleCycles(1, 1'b1);
        checkOutput("pop_cycle_rdy", req_rdy, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("pop_next_rdy", req_rdy, 1'b1);
        drain();

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 7'(i), 16'(16'hC3A0 ^ (i * 16'h1111)), 16'hFFFF, 1'b1, 1'b0, hs);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 7'(i), 16'h0000, 16'h0000, 1'b1, 1'b1, hs);
            checkOutput($sformatf("stream_hs_%0d", i), hs, 1'b1);
        end
        drain();

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 7'(i), 16'h0000, 16'h0000, 1'b0, 1'b0, hs);
        checkOutput("pre_rst_rsp_vld", rsp_vld, 1'b1);
        doReset();
        drain();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
